pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage MIPS core. It turns per-stage stall requests into the per-register stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It sequences exception and eret flushes, including redirect-PC selection and a one-cycle post-flush hold-off. It also keeps a saturating stall-cycle counter and a sticky stall-watchdog flag for debug.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_ctrl_sat_counter.sv | 35 +++
 rtl/pipe_ctrl.sv | 99 +++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: exception codes, stall
// encodings and the stall-request priority encoder.
package pipe_ctrl_pkg;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic RST_ENABLE = 1'b1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic mem;
        logic ex;
        logic id;
    } stall_req_t;

    // The deepest requesting stage wins, since it must freeze everything upstream.
    function automatic logic [5:0] stall_encode(input stall_req_t req);
        if (req.mem)
            return STALL_MEM;
        else if (req.ex)
            return STALL_EX;
        else if (req.id)
            return STALL_ID;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at LIMIT instead of wrapping.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int             W     = 8,
    parameter logic [W-1:0]   LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != LIMIT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector generation, exception/eret flush sequencing
// with a one-cycle post-flush hold-off, and stall statistics/watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = 32'h0000_0020,
    parameter int          TIMEOUT = 64,
    parameter int          CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout
);

    localparam int               RUN_W     = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(TIMEOUT);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             timeout_q;
    logic             timeout_d;
    logic [RUN_W-1:0] run_cnt;
    stall_req_t       req;

    assign req = '{mem: stallreq_mem, ex: stallreq_ex, id: stallreq_id};

    // Outputs are forced idle during reset so no stale redirect escapes.
    always_comb begin
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = 32'h0;
        state_d = ST_RUN;
        if (rst != RST_ENABLE) begin
            case (state_q)
                ST_RUN: begin
                    if (excepttype != 32'h0) begin
                        flush   = 1'b1;
                        new_pc  = (excepttype == EXC_ERET) ? cp0_epc : EXC_VEC;
                        state_d = ST_HOLD;
                    end else begin
                        stall = stall_encode(req);
                    end
                end
                // Requests seen here come from instructions that were just flushed.
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall[0]),
        .clr_i (1'b0),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .W     (RUN_W),
        .LIMIT (RUN_LIMIT)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall[0]),
        .clr_i (~stall[0]),
        .cnt_o (run_cnt)
    );

    // Set on the edge that completes the TIMEOUT-th consecutive stalled cycle.
    assign timeout_d = timeout_q | (stall[0] && (run_cnt >= RUN_LIMIT - 1'b1));

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            timeout_q <= 1'b0;
        else
            timeout_q <= timeout_d;
    end

    assign timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a queue-based scoreboard; the
// monitor checks every cycle's outputs against the hand-computed row.
module tb_pipe_ctrl;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stallreq_id = 1'b0;
    logic             stallreq_ex = 1'b0;
    logic             stallreq_mem = 1'b0;
    logic [31:0]      excepttype = 32'h0;
    logic [31:0]      cp0_epc = 32'h0;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic             timeout;

    pipe_ctrl #(
        .EXC_VEC (32'h0000_0020),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype   (excepttype),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        id;
        logic        ex;
        logic        mem;
        logic [31:0] exc;
        logic [31:0] epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_to;
    } vec_t;

    typedef struct {
        int          idx;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_to;
    } exp_t;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   stim_done = 1'b0;

    task automatic set_vec(input int i, input logic r, input logic id, input logic ex,
                           input logic mem, input logic [31:0] exc, input logic [31:0] epc,
                           input logic [5:0] es, input logic ef, input logic [31:0] ep,
                           input logic [2:0] ec, input logic et);
        vecs[i] = '{r, id, ex, mem, exc, epc, es, ef, ep, ec, et};
    endtask

    initial begin
        //            rst id ex mem exc           epc           stall      flush pc            cnt to
        set_vec( 0, 1, 0, 0, 1, 32'h8,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
        set_vec( 1, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        0, 0);
        set_vec( 2, 0, 1, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        0, 0);
        set_vec( 3, 0, 1, 1, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        1, 0);
        set_vec( 4, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
        set_vec( 5, 0, 0, 0, 1, 32'h8,        32'h0,        6'b000000, 1, 32'h20,       2, 0);
        set_vec( 6, 0, 0, 0, 1, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        2, 0);
        set_vec( 7, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        2, 0);
        set_vec( 8, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        3, 0);
        set_vec( 9, 0, 0, 0, 0, 32'he,        32'h1234,     6'b000000, 1, 32'h1234,     3, 0);
        set_vec(10, 0, 0, 0, 0, 32'h0,        32'h1234,     6'b000000, 0, 32'h0,        3, 0);
        set_vec(11, 0, 1, 0, 0, 32'he,        32'h1234,     6'b000000, 1, 32'h1234,     3, 0);
        set_vec(12, 0, 0, 0, 0, 32'he,        32'h1234,     6'b000000, 0, 32'h0,        3, 0);
        set_vec(13, 0, 0, 0, 0, 32'hc,        32'h1234,     6'b000000, 1, 32'h20,       3, 0);
        set_vec(14, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        3, 0);
        set_vec(15, 1, 0, 1, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        3, 0);
        set_vec(16, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        0, 0);
        set_vec(17, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        1, 0);
        set_vec(18, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        2, 0);
        set_vec(19, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        3, 0);
        set_vec(20, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        3, 0);
        set_vec(21, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        4, 0);
        set_vec(22, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        5, 0);
        set_vec(23, 0, 0, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0,        6, 0);
        set_vec(24, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        7, 1);
        set_vec(25, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        7, 1);
        set_vec(26, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        7, 1);
        set_vec(27, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        7, 1);
        set_vec(28, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        7, 1);
        set_vec(29, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        7, 1);
        set_vec(30, 1, 0, 0, 1, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        7, 1);
        set_vec(31, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0,        0, 0);
        set_vec(32, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
        set_vec(33, 0, 0, 0, 0, 32'h8,        32'h0,        6'b000000, 1, 32'h20,       1, 0);
        set_vec(34, 1, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        1, 0);
        set_vec(35, 0, 0, 0, 0, 32'h55,       32'h0,        6'b000000, 1, 32'h20,       0, 0);
        set_vec(36, 0, 0, 0, 1, 32'h0,        32'h0,        6'b000000, 0, 32'h0,        0, 0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            rst          = vecs[i].rst;
            stallreq_id  = vecs[i].id;
            stallreq_ex  = vecs[i].ex;
            stallreq_mem = vecs[i].mem;
            excepttype   = vecs[i].exc;
            cp0_epc      = vecs[i].epc;
            sb_q.push_back('{i, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc,
                             vecs[i].e_cnt, vecs[i].e_to});
        end
        @(posedge clk);
        #1;
        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excepttype = 32'h0;
        stim_done = 1'b1;
    end

    // Monitor: every cycle the DUT presents a response for the row issued this cycle.
    initial begin
        exp_t e;
        int   budget;
        budget = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                bit ok;
                e  = sb_q.pop_front();
                ok = 1'b1;
                n_tests++;
                if (stall !== e.e_stall) begin
                    n_fail++; ok = 1'b0;
                    $display("[TB] FAIL row%0d stall got %b want %b", e.idx, stall, e.e_stall);
                end
                n_tests++;
                if (flush !== e.e_flush) begin
                    n_fail++; ok = 1'b0;
                    $display("[TB] FAIL row%0d flush got %b want %b", e.idx, flush, e.e_flush);
                end
                n_tests++;
                if (new_pc !== e.e_pc) begin
                    n_fail++; ok = 1'b0;
                    $display("[TB] FAIL row%0d new_pc got %h want %h", e.idx, new_pc, e.e_pc);
                end
                n_tests++;
                if (stall_cnt !== e.e_cnt) begin
                    n_fail++; ok = 1'b0;
                    $display("[TB] FAIL row%0d stall_cnt got %0d want %0d", e.idx, stall_cnt, e.e_cnt);
                end
                n_tests++;
                if (timeout !== e.e_to) begin
                    n_fail++; ok = 1'b0;
                    $display("[TB] FAIL row%0d timeout got %b want %b", e.idx, timeout, e.e_to);
                end
                if (ok)
                    $display("[TB] row%0d ok stall=%b flush=%b new_pc=%h cnt=%0d to=%b",
                             e.idx, stall, flush, new_pc, stall_cnt, timeout);
            end else if (stim_done) begin
                break;
            end
            budget++;
            if (budget > 2000) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL watchdog cycles got %0d want <= 2000", budget);
                break;
            end
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
